// File: rtl/hub75_panel_driver.sv
// HUB75 LED-matrix scan driver.
// Double-buffered framebuffer readout with binary-coded-modulation colour depth.
// Each pass shifts one bit-plane of a row pair into the panel, latches it and
// unblanks for ON_TICKS<<plane ticks. Bit-planes run LSB first.
// Buffer swaps happen only at frame end, under a swapReq/swapAck handshake.
module hub75_panel_driver #(
    parameter int CLK_DIV    = 3,
    parameter int COLS       = 32,
    parameter int ROW_ADDR_W = 4,
    parameter int COLOR_BITS = 2,
    parameter int ON_TICKS   = 1,
    localparam int CW        = $clog2(COLS),
    localparam int ADDR_W    = 2 + ROW_ADDR_W + CW,
    localparam int PIX_W     = 3 * COLOR_BITS
) (
    input  logic                  clkIn,
    input  logic                  rst,
    output logic [ADDR_W-1:0]     pixelAddress0,
    input  logic [PIX_W-1:0]      pixel0,
    output logic [ADDR_W-1:0]     pixelAddress1,
    input  logic [PIX_W-1:0]      pixel1,
    output logic [ROW_ADDR_W-1:0] rowDecoder,
    output logic                  pixelClk,
    output logic [2:0]            columnPixels0,
    output logic [2:0]            columnPixels1,
    output logic                  columnLatch,
    output logic                  blank,
    input  logic                  swapReq,
    output logic                  swapAck,
    output logic                  bufSel,
    output logic                  done
);

    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW       = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int SHOW_MAX = ON_TICKS << (COLOR_BITS - 1);
    localparam int SW       = $clog2(SHOW_MAX + 1);

    // LATCH spans two ticks; the second tick is its own state (S_LATCH_END),
    // which also unblanks so the display window is exactly the SHOW length.
    typedef enum logic [2:0] {
        S_PREFETCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_LATCH_END,
        S_SHOW
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         divCnt_q, divCnt_d;
    logic [CW-1:0]         col_q, col_d;
    logic [ROW_ADDR_W-1:0] row_q, row_d;
    logic [PW-1:0]         plane_q, plane_d;
    logic [SW-1:0]         showCnt_q, showCnt_d;
    logic [ADDR_W-1:0]     addr0_q, addr0_d;
    logic [ADDR_W-1:0]     addr1_q, addr1_d;
    logic [ROW_ADDR_W-1:0] rowDec_q, rowDec_d;
    logic                  pclk_q, pclk_d;
    logic [2:0]            cp0_q, cp0_d;
    logic [2:0]            cp1_q, cp1_d;
    logic                  latch_q, latch_d;
    logic                  blank_q, blank_d;
    logic                  swapAck_q, swapAck_d;
    logic                  bufSel_q, bufSel_d;
    logic                  done_q, done_d;

    logic                  tick;
    logic                  lastCol;
    logic                  lastPlane;
    logic                  lastRow;
    logic                  frameEnd;
    logic [CW-1:0]         colNext;
    logic [SW-1:0]         showLen;
    logic [2:0]            planeBits0;
    logic [2:0]            planeBits1;

    // Pick bit 'plane' of each {R,G,B} channel for both half-panel pixels.
    always_comb begin
        planeBits0 = '0;
        planeBits1 = '0;
        for (int unsigned b = 0; b < COLOR_BITS; b++) begin
            if (plane_q == PW'(b)) begin
                planeBits0 = {pixel0[2*COLOR_BITS+b], pixel0[COLOR_BITS+b], pixel0[b]};
                planeBits1 = {pixel1[2*COLOR_BITS+b], pixel1[COLOR_BITS+b], pixel1[b]};
            end
        end
    end

    // Scan sequencer: divider, next-state and next-output logic.
    always_comb begin
        tick      = (divCnt_q == DW'(CLK_DIV - 1));
        lastCol   = (col_q == CW'(COLS - 1));
        lastPlane = (plane_q == PW'(COLOR_BITS - 1));
        lastRow   = (row_q == '1);
        colNext   = col_q + 1'b1;
        showLen   = SW'(ON_TICKS) << plane_q;

        divCnt_d  = tick ? '0 : divCnt_q + 1'b1;
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        plane_d   = plane_q;
        showCnt_d = showCnt_q;
        addr0_d   = addr0_q;
        addr1_d   = addr1_q;
        rowDec_d  = rowDec_q;
        pclk_d    = pclk_q;
        cp0_d     = cp0_q;
        cp1_d     = cp1_q;
        latch_d   = latch_q;
        blank_d   = blank_q;
        frameEnd  = 1'b0;

        if (tick) begin
            case (state_q)
                S_PREFETCH: begin
                    addr0_d = {bufSel_q, 1'b0, row_q, col_q};
                    addr1_d = {bufSel_q, 1'b1, row_q, col_q};
                    state_d = S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    cp0_d   = planeBits0;
                    cp1_d   = planeBits1;
                    pclk_d  = 1'b0;
                    addr0_d = {bufSel_q, 1'b0, row_q, colNext};
                    addr1_d = {bufSel_q, 1'b1, row_q, colNext};
                    state_d = S_SHIFT_HI;
                end
                S_SHIFT_HI: begin
                    pclk_d = 1'b1;
                    if (lastCol) begin
                        col_d   = '0;
                        state_d = S_LATCH;
                    end else begin
                        col_d   = colNext;
                        state_d = S_SHIFT_LO;
                    end
                end
                S_LATCH: begin
                    pclk_d   = 1'b0;
                    latch_d  = 1'b1;
                    rowDec_d = row_q;
                    state_d  = S_LATCH_END;
                end
                S_LATCH_END: begin
                    latch_d   = 1'b0;
                    blank_d   = 1'b0;
                    showCnt_d = '0;
                    state_d   = S_SHOW;
                end
                S_SHOW: begin
                    if (showCnt_q == showLen - 1'b1) begin
                        blank_d = 1'b1;
                        state_d = S_PREFETCH;
                        if (!lastPlane) begin
                            plane_d = plane_q + 1'b1;
                        end else begin
                            plane_d  = '0;
                            row_d    = row_q + 1'b1;
                            frameEnd = lastRow;
                        end
                    end else begin
                        showCnt_d = showCnt_q + 1'b1;
                    end
                end
                default: begin
                    blank_d = 1'b1;
                    state_d = S_PREFETCH;
                end
            endcase
        end

        done_d    = frameEnd;
        swapAck_d = frameEnd & swapReq;
        bufSel_d  = bufSel_q ^ (frameEnd & swapReq);
    end

    // State and output registers; reset blanks the panel immediately.
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            state_q   <= S_PREFETCH;
            divCnt_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            plane_q   <= '0;
            showCnt_q <= '0;
            addr0_q   <= '0;
            addr1_q   <= '0;
            rowDec_q  <= '0;
            pclk_q    <= 1'b0;
            cp0_q     <= '0;
            cp1_q     <= '0;
            latch_q   <= 1'b0;
            blank_q   <= 1'b1;
            swapAck_q <= 1'b0;
            bufSel_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            divCnt_q  <= divCnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            showCnt_q <= showCnt_d;
            addr0_q   <= addr0_d;
            addr1_q   <= addr1_d;
            rowDec_q  <= rowDec_d;
            pclk_q    <= pclk_d;
            cp0_q     <= cp0_d;
            cp1_q     <= cp1_d;
            latch_q   <= latch_d;
            blank_q   <= blank_d;
            swapAck_q <= swapAck_d;
            bufSel_q  <= bufSel_d;
            done_q    <= done_d;
        end
    end

    assign pixelAddress0 = addr0_q;
    assign pixelAddress1 = addr1_q;
    assign rowDecoder    = rowDec_q;
    assign pixelClk      = pclk_q;
    assign columnPixels0 = cp0_q;
    assign columnPixels1 = cp1_q;
    assign columnLatch   = latch_q;
    assign blank         = blank_q;
    assign swapAck       = swapAck_q;
    assign bufSel        = bufSel_q;
    assign done          = done_q;

endmodule

// File: tb/tb_hub75_panel_driver.sv
// Bench for hub75_panel_driver: a framebuffer RAM model, a scoreboard of
// expected shifted pixels / latched rows / display windows per frame, and a
// directed sequence covering reset, BCM timing, frame end and buffer swap.
module tb_hub75_panel_driver;

    localparam int CLK_DIV = 2;
    localparam int COLS    = 4;
    localparam int RW      = 1;
    localparam int CB      = 2;
    localparam int ON      = 1;
    localparam int AW      = 2 + RW + 2;
    localparam int FRAME   = 100;

    logic          clkIn   = 1'b0;
    logic          rst     = 1'b0;
    logic          swapReq = 1'b0;
    logic [AW-1:0] pa0, pa1;
    logic [5:0]    pixel0  = '0;
    logic [5:0]    pixel1  = '0;
    logic [RW-1:0] rowDec;
    logic          pclk, latch, blank, swapAck, bufSel, done;
    logic [2:0]    cp0, cp1;

    int checks = 0;
    int errors = 0;
    bit patMode = 1'b0;

    logic [6:0] expPix[$];
    int         expRow[$];
    int         expShow[$];

    hub75_panel_driver #(
        .CLK_DIV(CLK_DIV),
        .COLS(COLS),
        .ROW_ADDR_W(RW),
        .COLOR_BITS(CB),
        .ON_TICKS(ON)
    ) dut (
        .clkIn(clkIn),
        .rst(rst),
        .pixelAddress0(pa0),
        .pixel0(pixel0),
        .pixelAddress1(pa1),
        .pixel1(pixel1),
        .rowDecoder(rowDec),
        .pixelClk(pclk),
        .columnPixels0(cp0),
        .columnPixels1(cp1),
        .columnLatch(latch),
        .blank(blank),
        .swapReq(swapReq),
        .swapAck(swapAck),
        .bufSel(bufSel),
        .done(done)
    );

    always #5 clkIn = ~clkIn;

    // Framebuffer contents: mode 0 is the fixed pattern (top 10_01_11, bottom 0),
    // mode 1 a per-address hash so column/row/half/buffer errors show up.
    function automatic logic [5:0] pat(input logic [AW-1:0] a);
        int t;
        if (!patMode) return a[3] ? 6'd0 : 6'b100111;
        t = int'(a) * 13 + 7;
        return t[5:0];
    endfunction

    function automatic logic [2:0] planeBits(input logic [5:0] v, input int p);
        return {v[4+p], v[2+p], v[p]};
    endfunction

    // Synchronous RAM, one cycle latency.
    always @(posedge clkIn) begin
        pixel0 <= pat(pa0);
        pixel1 <= pat(pa1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pushFrame(input logic b);
        for (int r = 0; r < (1 << RW); r++) begin
            for (int p = 0; p < CB; p++) begin
                for (int c = 0; c < COLS; c++) begin
                    logic [AW-1:0] a0, a1;
                    a0 = {b, 1'b0, r[0], c[1:0]};
                    a1 = {b, 1'b1, r[0], c[1:0]};
                    expPix.push_back({b, planeBits(pat(a0), p), planeBits(pat(a1), p)});
                end
                expRow.push_back(r);
                expShow.push_back((ON << p) * CLK_DIV);
            end
        end
    endtask

    task automatic waitDone(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        repeat (400) begin
            @(posedge clkIn);
            #1;
            n++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // After a done pulse: handshake outcome, pulse width, scoreboard drained.
    task automatic frameEndChecks(input logic expAck, input logic expBuf);
        check("ack_at_done", swapAck, expAck);
        check("bufsel_at_done", bufSel, expBuf);
        @(posedge clkIn);
        #1;
        check("done_width", done, 0);
        check("ack_width", swapAck, 0);
        check("sb_empty", expPix.size() + expRow.size() + expShow.size(), 0);
    endtask

    bit prevPclk = 1'b0, prevLatch = 1'b0, prevBlank = 1'b1;
    int lowCnt = 0, latchCnt = 0;

    // Panel-side monitor, sampled on the falling clock edge.
    always @(negedge clkIn) begin : mon
        logic [6:0] e;
        int r;
        if (!rst) begin
            prevPclk  = 1'b0;
            prevLatch = 1'b0;
            prevBlank = 1'b1;
            lowCnt    = 0;
            latchCnt  = 0;
        end else begin
            if (pclk && !prevPclk) begin
                if (expPix.size() == 0) begin
                    check("pix_unexpected", 1, 0);
                end else begin
                    e = expPix.pop_front();
                    check("column_pixels", {cp0, cp1}, e[5:0]);
                    check("addr_buf", pa0[AW-1], e[6]);
                    check("addr_pair", {pa0[3], pa1}, {1'b0, pa0[4], 1'b1, pa0[2:0]});
                    check("blank_shift", blank, 1);
                end
            end
            if (latch && !prevLatch) begin
                if (expRow.size() == 0) begin
                    check("latch_unexpected", 1, 0);
                end else begin
                    r = expRow.pop_front();
                    check("row_decoder", rowDec, r);
                    check("blank_latch", blank, 1);
                end
            end
            if (latch) latchCnt++;
            if (!latch && prevLatch) begin
                check("latch_width", latchCnt, CLK_DIV);
                latchCnt = 0;
            end
            if (!blank) lowCnt++;
            if (blank && !prevBlank) begin
                if (expShow.size() == 0) begin
                    check("show_unexpected", 1, 0);
                end else begin
                    r = expShow.pop_front();
                    check("show_cycles", lowCnt, r);
                end
                lowCnt = 0;
            end
            prevPclk  = pclk;
            prevLatch = latch;
            prevBlank = blank;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;

        // Reset held: idle output values.
        repeat (3) @(negedge clkIn);
        check("rst_pa0", pa0, 0);
        check("rst_pa1", pa1, 0);
        check("rst_rowdec", rowDec, 0);
        check("rst_pclk", pclk, 0);
        check("rst_cp0", cp0, 0);
        check("rst_cp1", cp1, 0);
        check("rst_latch", latch, 0);
        check("rst_blank", blank, 1);
        check("rst_ack", swapAck, 0);
        check("rst_bufsel", bufSel, 0);
        check("rst_done", done, 0);

        // Frame 1: fixed pattern, release reset mid-cycle.
        patMode = 1'b0;
        pushFrame(1'b0);
        #2 rst = 1'b1;
        @(posedge clkIn);
        #1;
        check("pre_tick_pa1", pa1, 0);
        @(posedge clkIn);
        #1;
        check("first_pa0", pa0, 5'b00000);
        check("first_pa1", pa1, 5'b01000);
        waitDone(n, ok);
        check("done_f1", ok, 1);
        frameEndChecks(1'b0, 1'b0);

        // Frame 2: hashed pattern, no swap request.
        patMode = 1'b1;
        pushFrame(1'b0);
        waitDone(n, ok);
        check("done_f2", ok, 1);
        check("period_f2", n + 1, FRAME);
        frameEndChecks(1'b0, 1'b0);

        // Frame 3: request raised mid-frame, honoured only at frame end.
        pushFrame(1'b0);
        repeat (30) @(posedge clkIn);
        #1 swapReq = 1'b1;
        repeat (20) @(posedge clkIn);
        #1;
        check("midframe_bufsel", bufSel, 0);
        check("midframe_ack", swapAck, 0);
        waitDone(n, ok);
        check("done_f3", ok, 1);
        check("period_f3", n + 51, FRAME);
        frameEndChecks(1'b1, 1'b1);

        // Frame 4: request held high swaps again.
        pushFrame(1'b1);
        waitDone(n, ok);
        check("done_f4", ok, 1);
        check("period_f4", n + 1, FRAME);
        frameEndChecks(1'b1, 1'b0);

        // Frame 5: swap to buffer 1, then drop the request.
        pushFrame(1'b0);
        waitDone(n, ok);
        check("done_f5", ok, 1);
        swapReq = 1'b0;
        frameEndChecks(1'b1, 1'b1);

        // Frame 6: reset while unblanked.
        pushFrame(1'b1);
        ok = 1'b0;
        repeat (200) begin
            @(posedge clkIn);
            #1;
            if (!blank) begin
                ok = 1'b1;
                break;
            end
        end
        check("show_seen", ok, 1);
        rst = 1'b0;
        #1;
        check("async_blank", blank, 1);
        check("async_bufsel", bufSel, 0);
        check("async_pclk", pclk, 0);
        check("async_latch", latch, 0);
        repeat (3) @(negedge clkIn);
        expPix.delete();
        expRow.delete();
        expShow.delete();

        // Frame 7: scan restarts at row 0, plane 0, column 0 on buffer 0.
        pushFrame(1'b0);
        #2 rst = 1'b1;
        waitDone(n, ok);
        check("done_f7", ok, 1);
        frameEndChecks(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
